// File: rtl/seg_scan_driver.sv
// Four-digit common-anode seven-segment scanner with frame-boundary snapshot
// and a blank interval at the start of every digit slot.
module seg_scan_driver #(
  parameter int TICK_DIV = 50000,
  parameter int BLANK    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] seg_a,
  input  logic [6:0] seg_b,
  input  logic [6:0] seg_c,
  input  logic [6:0] seg_d,
  output logic [6:0] seg_out,
  output logic [3:0] an,
  output logic [1:0] digit_sel,
  output logic       frame_start
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_MAX   = cnt_t'(TICK_DIV - 1);
  localparam cnt_t CNT_BLANK = cnt_t'(BLANK);

  logic       en_q;
  cnt_t       cnt, cnt_n;
  logic [1:0] idx, idx_n;
  logic [6:0] sh   [4];
  logic [6:0] sh_n [4];
  logic       slot_end, snap;

  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic [1:0] sel_n;
  logic       fs_n;

  // Next-state: counters run only while en_q is set; the shadow copy is
  // refreshed while idle or on the very last cycle of a frame.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    cnt_n    = '0;
    idx_n    = '0;
    slot_end = (cnt == CNT_MAX);
    snap     = !en_q || (slot_end && (idx == 2'd3));
    if (en_q) begin
      cnt_n = slot_end ? '0 : cnt + 1'b1;
      idx_n = slot_end ? idx + 1'b1 : idx;
    end
    sh_n[0] = snap ? seg_a : sh[0];
    sh_n[1] = snap ? seg_b : sh[1];
    sh_n[2] = snap ? seg_c : sh[2];
    sh_n[3] = snap ? seg_d : sh[3];
  end

  // Outputs are decoded from next-state values so they can be registered
  // without adding a cycle of lag.
  always_comb begin
    seg_n = 7'h7F;
    an_n  = 4'hF;
    sel_n = 2'd0;
    fs_n  = 1'b0;
    if (enable) begin
      sel_n = idx_n;
      fs_n  = (idx_n == 2'd0) && (cnt_n == '0);
      if (cnt_n >= CNT_BLANK) begin
        an_n  = ~(4'b0001 << idx_n);
        seg_n = sh_n[idx_n];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q        <= 1'b0;
      cnt         <= '0;
      idx         <= 2'd0;
      // NOTE: the shadow array is reset too, so a dark pattern is held until the first snapshot.
      for (int i = 0; i < 4; i++) sh[i] <= 7'h7F;
      seg_out     <= 7'h7F;
      an          <= 4'hF;
      digit_sel   <= 2'd0;
      frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      en_q        <= enable;
      cnt         <= cnt_n;
      idx         <= idx_n;
      for (int i = 0; i < 4; i++) sh[i] <= sh_n[i];
      seg_out     <= seg_n;
      an          <= an_n;
      digit_sel   <= sel_n;
      frame_start <= fs_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: directed scenarios plus randomized
// input/enable traffic compared against a frame-time reference model.
module tb_seg_scan_driver;

  localparam int TD = 8;
  localparam int BL = 2;
  localparam int FRAME = 4 * TD;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [6:0] seg_a = 7'h00, seg_b = 7'h00, seg_c = 7'h00, seg_d = 7'h00;
  logic [6:0] seg_out;
  logic [3:0] an;
  logic [1:0] digit_sel;
  logic       frame_start;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: scanning flag, time within frame, snapshot of patterns.
  bit         m_run = 1'b0;
  int         m_t = 0;
  logic [6:0] m_snap [4] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};

  seg_scan_driver #(.TICK_DIV(TD), .BLANK(BL)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
    .seg_out(seg_out), .an(an), .digit_sel(digit_sel), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_run = 1'b0;
      m_t   = 0;
      for (int i = 0; i < 4; i++) m_snap[i] = 7'h7F;
      return;
    end
    if (!m_run) begin
      m_t    = 0;
      m_snap = '{seg_a, seg_b, seg_c, seg_d};
    end else begin
      m_t++;
      if (m_t == FRAME) begin
        m_t    = 0;
        m_snap = '{seg_a, seg_b, seg_c, seg_d};
      end
    end
    m_run = enable;
  endtask

  function automatic bit m_lit();
    return m_run && ((m_t % TD) >= BL);
  endfunction

  function automatic logic [3:0] exp_an();
    logic [3:0] one = 4'b0001;
    if (!m_lit()) return 4'hF;
    return ~(one << (m_t / TD));
  endfunction

  function automatic logic [6:0] exp_seg();
    if (!m_lit()) return 7'h7F;
    return m_snap[m_t / TD];
  endfunction

  task automatic compare_all();
    check("an", an, exp_an());
    check("seg_out", seg_out, exp_seg());
    check("digit_sel", digit_sel, m_run ? (m_t / TD) : 0);
    check("frame_start", frame_start, m_run && (m_t == 0));
    check("one_anode", $countones(~an) <= 1, 1);
    check("dark_seg", (an == 4'hF) ? seg_out : 7'h7F, 7'h7F);
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic load_plan_patterns();
    seg_a = 7'h40; seg_b = 7'h79; seg_c = 7'h24; seg_d = 7'h30;
  endtask

  initial begin
    int k;
    int prev_sel;
    int since_change;
    logic [6:0] new_a;

    // Reset and power-up frame
    load_plan_patterns();
    enable = 1'b1;
    #2 reset = 1'b1;
    repeat (2) step();
    check("reset_an", an, 4'hF);
    check("reset_seg", seg_out, 7'h7F);
    reset = 1'b0;
    step();
    check("e1_frame_start", frame_start, 1'b1);
    check("e1_an", an, 4'hF);
    k = 0;
    do begin step(); k++; end while (!frame_start && k < 100);
    check("frame_period", k, FRAME);
    repeat (40) step();

    // No tearing: change digit 2 pattern while digit 1 is scanning
    k = 0;
    while (!(m_run && (m_t / TD) == 1) && k < 100) begin step(); k++; end
    check("wait_slot1", k < 100, 1'b1);
    seg_c = 7'h12;
    k = 0;
    while (!(m_t == 2 * TD + BL) && k < 100) begin step(); k++; end
    check("wait_slot2", k < 100, 1'b1);
    check("old_digit2", seg_out, 7'h24);
    check("old_digit2_an", an, 4'hB);
    repeat (FRAME) step();
    check("new_digit2", seg_out, 7'h12);

    // Blank window after every digit change, random pattern traffic
    prev_sel = digit_sel;
    since_change = 4;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: seg_a = 7'($urandom);
          1: seg_b = 7'($urandom);
          2: seg_c = 7'($urandom);
          default: seg_d = 7'($urandom);
        endcase
      end
      step();
      if (digit_sel != prev_sel[1:0]) since_change = 1;
      else if (since_change < 4) since_change++;
      prev_sel = digit_sel;
      if (since_change <= 2) check("blank_after_sel", an, 4'hF);
      else if (since_change == 3) check("lit_after_blank", an == 4'hF, 1'b0);
    end

    // Enable drop mid-slot and restart
    k = 0;
    while (!(m_run && m_t == 2 * TD + 5) && k < 100) begin step(); k++; end
    check("wait_drop", k < 100, 1'b1);
    enable = 1'b0;
    step();
    check("drop_an", an, 4'hF);
    check("drop_sel", digit_sel, 2'd0);
    step();
    new_a = 7'($urandom) | 7'h01;
    seg_a = new_a;
    enable = 1'b1;
    step();
    check("restart_fs", frame_start, 1'b1);
    check("restart_an", an, 4'hF);
    repeat (BL) step();
    check("restart_an_lit", an, 4'hE);
    check("restart_seg", seg_out, new_a);

    // Random traffic including enable toggles
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        seg_a = 7'($urandom); seg_b = 7'($urandom);
        seg_c = 7'($urandom); seg_d = 7'($urandom);
      end
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      step();
    end

    // Asynchronous reset while digit 2 is lit
    enable = 1'b1;
    load_plan_patterns();
    k = 0;
    while (!(an == 4'hB) && k < 100) begin step(); k++; end
    check("wait_an_b", k < 100, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_an", an, 4'hF);
    check("async_seg", seg_out, 7'h7F);
    check("async_sel", digit_sel, 2'd0);
    check("async_fs", frame_start, 1'b0);
    step();
    reset = 1'b0;
    step();
    check("rerun_fs", frame_start, 1'b1);
    repeat (BL) step();
    check("rerun_an0", an, 4'hE);
    check("rerun_seg0", seg_out, 7'h40);
    repeat (TD) step();
    check("rerun_seg1", seg_out, 7'h79);
    repeat (TD) step();
    check("rerun_seg2", seg_out, 7'h24);
    repeat (TD) step();
    check("rerun_seg3", seg_out, 7'h30);
    check("rerun_an3", an, 4'h7);
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
